perf_tx_queue: RTL and testbench

//  Peripheral consumer directly downstream of the CPU peripheral-access stage.

---
 rtl/perf_tx_queue.sv | 119 +++++++++++
 tb/tb_perf_tx_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/perf_tx_queue.sv
// perf_tx_queue: register-mapped peripheral sitting behind the CPU peripheral
// access stage. TXDATA writes feed a first-word-fallthrough FIFO that drains to
// an external consumer; STATUS and two saturating counters are CPU-readable.
//
// Handshake (m_valid/m_ready): m_valid is high whenever the FIFO holds a word
// and m_data is stable while m_valid is high and m_ready is low. A transfer
// happens at every rising edge where m_valid and m_ready are both high. m_valid
// never depends combinationally on m_ready.
module perf_tx_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              perf_en,
  input  logic              perf_wren,
  input  logic [63:0]       perf_addr,
  input  logic [DATA_W-1:0] perf_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       rd_data,
  output logic              rd_valid,
  output logic              fifo_full,
  output logic              fifo_empty
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] SEL_TXDATA = 3'd0;
  localparam logic [2:0] SEL_CTRL   = 3'd1;
  localparam logic [2:0] SEL_STATUS = 3'd2;
  localparam logic [2:0] SEL_PUSH   = 3'd3;
  localparam logic [2:0] SEL_DROP   = 3'd4;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count;
  logic [31:0]         push_cnt, drop_cnt;
  logic [2:0]          sel;
  logic                wr_acc, rd_acc, push, pop, push_ok, drop, flush, clr;
  logic [63:0]         status, rd_mux;

  // Access decode: every perf_en cycle is exactly one access.
  assign sel     = perf_addr[5:3];
  assign wr_acc  = perf_en & perf_wren;
  assign rd_acc  = perf_en & ~perf_wren;
  assign push    = wr_acc & (sel == SEL_TXDATA);
  assign flush   = wr_acc & (sel == SEL_CTRL) & perf_data[0];
  assign clr     = wr_acc & (sel == SEL_CTRL) & perf_data[1];

  // Occupancy comes straight from the pointers; the extra wrap bit separates
  // full (difference == DEPTH) from empty (difference == 0).
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign m_valid    = ~fifo_empty;
  assign m_data     = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // A push into a full FIFO survives only when the head leaves in the same cycle.
  assign pop     = m_valid & m_ready;
  assign push_ok = push & (~fifo_full | pop);
  assign drop    = push & fifo_full & ~pop;

  // FIFO storage carries no reset; its contents only matter between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= perf_data;
  end

  // Pointer update; flush wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Saturating accepted/dropped push counters, cleared by CTRL bit1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      push_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok && push_cnt != CNT_MAX) push_cnt <= push_cnt + 32'd1;
      if (drop && drop_cnt != CNT_MAX)    drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // Read mux over pre-edge state; unmapped and write-only registers read 0.
  always_comb begin
    status = '0;
    status[0] = fifo_empty;
    status[1] = fifo_full;
    status[8 +: DEPTH_LOG2+1] = count;
    rd_mux = '0;
    case (sel)
      SEL_STATUS: rd_mux = status;
      SEL_PUSH:   rd_mux = {32'd0, push_cnt};
      SEL_DROP:   rd_mux = {32'd0, drop_cnt};
      default:    rd_mux = '0;
    endcase
  end

  // Registered read response: one-cycle rd_valid pulse, rd_data held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perf_tx_queue.sv
// Directed bench for perf_tx_queue: a vector table for single-cycle register
// and FIFO behaviour, then hand-written sequences for fill/drop, push on full
// with pop, flush, counter clear and mid-operation reset.
module tb_perf_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        perf_en, perf_wren, m_ready;
  logic [63:0] perf_addr, perf_data;
  logic [63:0] m_data, rd_data;
  logic        m_valid, rd_valid, fifo_full, fifo_empty;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  perf_tx_queue #(.DEPTH_LOG2(4), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .perf_en(perf_en), .perf_wren(perf_wren),
    .perf_addr(perf_addr), .perf_data(perf_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        wren;
    logic [63:0] addr;
    logic [63:0] data;
    logic        rdy;
    logic        exp_rv;
    logic [63:0] exp_rd;
    logic        exp_mv;
    logic [63:0] exp_md;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle outputs away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wren, input logic [63:0] addr,
                       input logic [63:0] data, input logic rdy);
    perf_en   = en;
    perf_wren = wren;
    perf_addr = addr;
    perf_data = data;
    m_ready   = rdy;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic rdy);
    drive(1'b1, 1'b1, addr, data, rdy);
    step();
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic do_read(input string name, input logic [63:0] addr, input logic [63:0] exp);
    drive(1'b1, 1'b0, addr, 64'd0, 1'b0);
    step();
    check({name, "_rd_valid"}, {63'd0, rd_valid}, 64'd1);
    check(name, rd_data, exp);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    // Vector table: {en, wren, addr, data, m_ready, exp rd_valid, exp rd_data, exp m_valid, exp m_data}
    vt[0]  = '{1'b1, 1'b0, 64'h1_0000_0010, 64'h0,  1'b0, 1'b1, 64'h1,   1'b0, 64'h0};
    vt[1]  = '{1'b1, 1'b1, 64'h1_0000_0000, 64'hA,  1'b0, 1'b0, 64'h1,   1'b1, 64'hA};
    vt[2]  = '{1'b1, 1'b1, 64'h1_0000_0000, 64'hB,  1'b0, 1'b0, 64'h1,   1'b1, 64'hA};
    vt[3]  = '{1'b1, 1'b1, 64'h1_0000_0000, 64'hC,  1'b0, 1'b0, 64'h1,   1'b1, 64'hA};
    vt[4]  = '{1'b1, 1'b0, 64'h1_0000_0010, 64'h0,  1'b0, 1'b1, 64'h300, 1'b1, 64'hA};
    vt[5]  = '{1'b0, 1'b0, 64'h0,           64'h0,  1'b1, 1'b0, 64'h300, 1'b1, 64'hB};
    vt[6]  = '{1'b0, 1'b0, 64'h0,           64'h0,  1'b1, 1'b0, 64'h300, 1'b1, 64'hC};
    vt[7]  = '{1'b0, 1'b0, 64'h0,           64'h0,  1'b1, 1'b0, 64'h300, 1'b0, 64'h0};
    vt[8]  = '{1'b1, 1'b0, 64'h18,          64'h0,  1'b0, 1'b1, 64'h3,   1'b0, 64'h0};
    vt[9]  = '{1'b1, 1'b0, 64'h20,          64'h0,  1'b0, 1'b1, 64'h0,   1'b0, 64'h0};
    vt[10] = '{1'b1, 1'b0, 64'h1F,          64'h0,  1'b0, 1'b1, 64'h3,   1'b0, 64'h0};
    vt[11] = '{1'b0, 1'b1, 64'h0,           64'h77, 1'b0, 1'b0, 64'h3,   1'b0, 64'h0};
    vt[12] = '{1'b1, 1'b1, 64'h10,          64'hFF, 1'b0, 1'b0, 64'h3,   1'b0, 64'h0};
    vt[13] = '{1'b1, 1'b1, 64'h38,          64'h1,  1'b0, 1'b0, 64'h3,   1'b0, 64'h0};
    vt[14] = '{1'b1, 1'b0, 64'h38,          64'h0,  1'b0, 1'b1, 64'h0,   1'b0, 64'h0};
    vt[15] = '{1'b1, 1'b0, 64'h10,          64'h0,  1'b0, 1'b1, 64'h1,   1'b0, 64'h0};

    // Reset
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_m_valid",    {63'd0, m_valid},    64'd0);
    check("reset_fifo_empty", {63'd0, fifo_empty}, 64'd1);
    check("reset_fifo_full",  {63'd0, fifo_full},  64'd0);
    check("reset_rd_valid",   {63'd0, rd_valid},   64'd0);
    check("reset_rd_data",    rd_data,             64'd0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].en, vt[i].wren, vt[i].addr, vt[i].data, vt[i].rdy);
      step();
      check($sformatf("vec%0d_rd_valid", i), {63'd0, rd_valid}, {63'd0, vt[i].exp_rv});
      check($sformatf("vec%0d_rd_data", i), rd_data, vt[i].exp_rd);
      check($sformatf("vec%0d_m_valid", i), {63'd0, m_valid}, {63'd0, vt[i].exp_mv});
      check($sformatf("vec%0d_fifo_empty", i), {63'd0, fifo_empty}, {63'd0, ~vt[i].exp_mv});
      check($sformatf("vec%0d_fifo_full", i), {63'd0, fifo_full}, 64'd0);
      if (vt[i].exp_mv) check($sformatf("vec%0d_m_data", i), m_data, vt[i].exp_md);
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);

    // Clear counters, fill to 16, then a push into the full FIFO is dropped
    do_write(64'h08, 64'h2, 1'b0);
    do_read("clr_push_cnt", 64'h18, 64'h0);
    for (int i = 0; i < 16; i++) do_write(64'h1_0000_0000, 64'h100 + 64'(i), 1'b0);
    check("fill_full", {63'd0, fifo_full}, 64'd1);
    do_read("fill_status", 64'h10, 64'h1002);
    do_write(64'h1_0000_0000, 64'hDEAD, 1'b0);
    check("drop_full", {63'd0, fifo_full}, 64'd1);
    check("drop_head", m_data, 64'h100);
    do_read("drop_cnt", 64'h20, 64'h1);
    do_read("drop_push_cnt", 64'h18, 64'h10);

    // Full FIFO: push with a same-cycle pop is accepted, occupancy stays 16
    do_write(64'h1_0000_0000, 64'h55, 1'b1);
    check("pushpop_full", {63'd0, fifo_full}, 64'd1);
    check("pushpop_head", m_data, 64'h101);
    do_read("pushpop_status", 64'h10, 64'h1002);
    for (int i = 1; i < 16; i++) exp_q.push_back(64'h100 + 64'(i));
    exp_q.push_back(64'h55);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_m_valid", i), {63'd0, m_valid}, 64'd1);
      check($sformatf("drain%0d_m_data", i), m_data, exp_q.pop_front());
      step();
    end
    m_ready = 1'b0;
    check("drain_done_m_valid", {63'd0, m_valid}, 64'd0);
    do_read("drain_push_cnt", 64'h18, 64'h11);

    // Flush with a competing pop, then clear both counters
    for (int i = 0; i < 5; i++) do_write(64'h0, 64'h200 + 64'(i), 1'b0);
    do_read("pre_flush_status", 64'h10, 64'h500);
    do_write(64'h08, 64'h1, 1'b1);
    check("flush_m_valid", {63'd0, m_valid}, 64'd0);
    check("flush_empty", {63'd0, fifo_empty}, 64'd1);
    do_read("flush_status", 64'h10, 64'h1);
    do_read("flush_keeps_push_cnt", 64'h18, 64'h16);
    do_write(64'h08, 64'h2, 1'b0);
    do_read("clr2_push_cnt", 64'h18, 64'h0);
    do_read("clr2_drop_cnt", 64'h20, 64'h0);

    // Mid-operation reset with queued data, a pending pop and a live access
    for (int i = 0; i < 7; i++) do_write(64'h0, 64'h300 + 64'(i), 1'b0);
    do_read("pre_rst_status", 64'h10, 64'h700);
    drive(1'b1, 1'b0, 64'h10, 64'd0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    do_read("rst_status", 64'h10, 64'h1);
    do_read("rst_push_cnt", 64'h18, 64'h0);
    do_read("rst_unmapped", 64'h38, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
